// File: rtl/ext_mem_reader.sv
// Memory readback engine: holds the CPU in reset and streams a word-aligned window of data memory out over valid/ready.
// Optional feature: define EXT_RD_CHECKSUM_EN to build the running 32-bit checksum of dumped words.
module ext_mem_reader #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             hold_cpu,
    output logic [31:0]      Ext_DataAdr,
    input  logic [31:0]      ReadData,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [31:0]      checksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]      addr;
    logic [CNT_W-1:0] remaining;
    logic             busy_q;

    logic accept;
    logic capture;
    logic handshake;
    logic advance;
    logic last_word;

    // Byte address arithmetic wraps modulo 2^32.
    function automatic logic [31:0] next_word_addr(input logic [31:0] a);
        return a + 32'd4;
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    logic unused_low_bits;
    assign unused_low_bits = ^base_addr[1:0];

    assign last_word = (remaining == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (word_count == '0) ? FIN : RD;
                end
            end
            RD: begin
                capture   = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (out_valid && out_ready) begin
                    handshake = 1'b1;
                    if (last_word) begin
                        state_nxt = FIN;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = RD;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address walk, capture register and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= 32'h0;
            remaining <= '0;
            out_data  <= 32'h0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (accept) begin
                addr      <= align_word(base_addr);
                remaining <= word_count;
                busy_q    <= 1'b1;
            end
            if (capture) begin
                out_data  <= ReadData;
                out_valid <= 1'b1;
                out_last  <= last_word;
            end
            if (handshake) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                if (last_word) begin
                    busy_q <= 1'b0;
                end
            end
            if (advance) begin
                addr      <= next_word_addr(addr);
                remaining <= remaining - CNT_W'(1);
            end
            // An empty dump keeps busy through its single FIN cycle.
            if (state == FIN) begin
                busy_q <= 1'b0;
            end
        end
    end

`ifdef EXT_RD_CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= 32'h0;
        end else if (accept) begin
            csum <= 32'h0;
        end else if (capture) begin
            csum <= csum + ReadData;
        end
    end

    assign checksum = csum;
`else
    assign checksum = 32'h0;
`endif

    assign hold_cpu    = (state == RD) || (state == SEND);
    assign done        = (state == FIN);
    assign busy        = busy_q;
    assign Ext_DataAdr = addr;

endmodule

// File: tb/tb_ext_mem_reader.sv
// Directed bench for ext_mem_reader: small combinational memory model and hand-computed expected beats.
module tb_ext_mem_reader;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      base_addr;
    logic [CNT_W-1:0] word_count;
    logic             hold_cpu;
    logic [31:0]      Ext_DataAdr;
    logic [31:0]      ReadData;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [31:0]      checksum;

    logic [31:0] mem [0:15];

    ext_mem_reader #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .hold_cpu   (hold_cpu),
        .Ext_DataAdr(Ext_DataAdr),
        .ReadData   (ReadData),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    assign ReadData = mem[Ext_DataAdr[5:2]];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] got_data [0:7];
    logic [31:0] got_addr [0:7];
    logic        got_last [0:7];
    int          nbeats;
    int          done_cyc;
    int          done_pulses;
    int          first_vld_cyc;
    logic        hold_seen;
    logic        busy_k0;
    logic        busy_k1;
    logic        busy_at_done;
    logic        hold_at_done;
    logic [31:0] csum_done;
    logic [31:0] csum_after;
    logic [31:0] exp_sum4;
    logic [31:0] exp_sum2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [CNT_W-1:0] c);
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        @(posedge clk);
        #1;
        start      = 1'b0;
        base_addr  = 32'hDEAD_BEE0;
        word_count = 16'd7;
    endtask

    // k counts falling edges after the start-accepting edge (k=0 is the first).
    task automatic run_dump(input logic [31:0] b, input logic [CNT_W-1:0] c,
                            input int stall_beat, input bit restart);
        int stall;
        stall         = 0;
        nbeats        = 0;
        done_cyc      = -1;
        done_pulses   = 0;
        first_vld_cyc = -1;
        hold_seen     = 1'b0;
        busy_k0       = 1'b0;
        busy_k1       = 1'b0;
        busy_at_done  = 1'b1;
        hold_at_done  = 1'b1;
        csum_done     = 32'hX;
        csum_after    = 32'hX;
        out_ready     = 1'b1;
        pulse_start(b, c);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k == 0) busy_k0 = busy;
            if (k == 1) busy_k1 = busy;
            if (hold_cpu) hold_seen = 1'b1;
            if (restart && k == 2) begin
                start      = 1'b1;
                base_addr  = 32'h10;
                word_count = 16'd1;
            end
            if (restart && k == 3) start = 1'b0;
            out_ready = 1'b1;
            if (out_valid && first_vld_cyc < 0) first_vld_cyc = k;
            if (out_valid && nbeats == stall_beat && stall < 5) begin
                out_ready = 1'b0;
                stall++;
                chk("stall_data", out_data, 32'h22);
                chk("stall_hold", hold_cpu, 1'b1);
                chk("stall_addr", Ext_DataAdr, 32'h4);
            end
            if (out_valid && out_ready) begin
                if (nbeats < 8) begin
                    got_data[nbeats] = out_data;
                    got_addr[nbeats] = Ext_DataAdr;
                    got_last[nbeats] = out_last;
                end
                nbeats++;
            end
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) begin
                    done_cyc     = k;
                    busy_at_done = busy;
                    hold_at_done = hold_cpu;
                    csum_done    = checksum;
                end
            end
            if (done_cyc >= 0 && k == done_cyc + 2) begin
                csum_after = checksum;
                break;
            end
        end
    endtask

    task automatic check_four_beats(input string tag, input int exp_done);
        chk({tag, "_nbeats"}, nbeats, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_data[i], 32'h11 * (i + 1));
            chk($sformatf("%s_addr%0d", tag, i), got_addr[i], 32'(4 * i));
            chk($sformatf("%s_last%0d", tag, i), got_last[i], (i == 3) ? 1'b1 : 1'b0);
        end
        chk({tag, "_first_vld"}, first_vld_cyc, 1);
        chk({tag, "_done_cyc"}, done_cyc, exp_done);
        chk({tag, "_done_pulses"}, done_pulses, 1);
        chk({tag, "_busy_k0"}, busy_k0, 1'b1);
        chk({tag, "_busy_at_done"}, busy_at_done, 1'b0);
        chk({tag, "_hold_at_done"}, hold_at_done, 1'b0);
        chk({tag, "_csum_done"}, csum_done, exp_sum4);
        chk({tag, "_csum_after"}, csum_after, exp_sum4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;
        mem[4] = 32'h55;
        mem[5] = 32'h66;
`ifdef EXT_RD_CHECKSUM_EN
        exp_sum4 = 32'hAA;
        exp_sum2 = 32'hBB;
`else
        exp_sum4 = 32'h0;
        exp_sum2 = 32'h0;
`endif
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = 32'h0;
        word_count = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold", hold_cpu, 1'b0);
        chk("rst_addr", Ext_DataAdr, 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_csum", checksum, 32'h0);
        reset = 1'b0;

        run_dump(32'h0, 16'd4, -1, 1'b0);
        check_four_beats("basic", 8);

        run_dump(32'h0, 16'd0, -1, 1'b0);
        chk("zero_nbeats", nbeats, 0);
        chk("zero_first_vld", first_vld_cyc, -1);
        chk("zero_done_cyc", done_cyc, 0);
        chk("zero_done_pulses", done_pulses, 1);
        chk("zero_hold_seen", hold_seen, 1'b0);
        chk("zero_busy_k0", busy_k0, 1'b1);
        chk("zero_busy_k1", busy_k1, 1'b0);
        chk("zero_csum", csum_done, 32'h0);

        run_dump(32'h0, 16'd4, 1, 1'b0);
        check_four_beats("stall", 13);

        run_dump(32'h0000_0013, 16'd2, -1, 1'b0);
        chk("align_nbeats", nbeats, 2);
        chk("align_addr0", got_addr[0], 32'h10);
        chk("align_addr1", got_addr[1], 32'h14);
        chk("align_data0", got_data[0], 32'h55);
        chk("align_data1", got_data[1], 32'h66);
        chk("align_last0", got_last[0], 1'b0);
        chk("align_last1", got_last[1], 1'b1);
        chk("align_done_cyc", done_cyc, 4);
        chk("align_csum", csum_done, exp_sum2);

        // Reset while the second word is waiting in SEND.
        out_ready = 1'b1;
        pulse_start(32'h0, 16'd4);
        repeat (4) @(negedge clk);
        chk("mid_pre_valid", out_valid, 1'b1);
        chk("mid_pre_data", out_data, 32'h22);
        reset     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("mid_hold", hold_cpu, 1'b0);
        chk("mid_addr", Ext_DataAdr, 32'h0);
        chk("mid_data", out_data, 32'h0);
        chk("mid_valid", out_valid, 1'b0);
        chk("mid_last", out_last, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_csum", checksum, 32'h0);
        reset     = 1'b0;
        out_ready = 1'b1;
        done_pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done || out_valid || hold_cpu) done_pulses++;
        end
        chk("mid_quiet_after", done_pulses, 0);

        run_dump(32'h0, 16'd4, -1, 1'b1);
        check_four_beats("restart", 8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
